// File: rtl/nibble_adder_seq.sv
// rtl/nibble_adder_seq.sv - W-bit add/subtract sequenced one nibble per step through an external 4-bit CPA.
// Operands are latched on start; each nibble waits SETTLE cycles before its sum and carry are captured.
module nibble_adder_seq #(
  parameter int NIBBLES = 4,
  parameter int SETTLE  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic [3:0]             cpa_a,
  output logic [3:0]             cpa_b,
  output logic                   cpa_cin,
  input  logic [3:0]             cpa_s,
  input  logic                   cpa_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic          w_capture;
  logic          w_last;

  assign w_capture = (r_state == S_RUN) && (r_cnt == '0);
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    done    = 1'b0;
    cpa_a   = 4'h0;
    cpa_b   = 4'h0;
    cpa_cin = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        cpa_a   = r_a[{r_idx, 2'b00} +: 4];
        cpa_b   = r_b[{r_idx, 2'b00} +: 4];
        cpa_cin = r_carry;
        if (w_capture && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Final nibble carries the sign bit, so overflow uses cpa_s[3] directly at the last capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_idx   <= '0;
            r_cnt   <= SETTLE_C;
          end
        end
        S_RUN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            sum[{r_idx, 2'b00} +: 4] <= cpa_s;
            r_carry                  <= cpa_cout;
            if (w_last) begin
              cout <= cpa_cout;
              ovf  <= (r_a[W-1] == r_b[W-1]) && (cpa_s[3] != r_a[W-1]);
            end else begin
              r_idx <= r_idx + IW'(1);
              r_cnt <= SETTLE_C;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
